// File: rtl/mbox_framer_if.sv
// Mailbox byte-write and WOU transmit signals grouped for the mbox_framer boundary.
// slave = framer side, master = mailbox/transmitter side.
interface mbox_framer_if;
  logic       mbox_wr_i;
  logic [7:0] mbox_di_i;
  logic       mbox_full_o;
  logic       mbox_afull_o;
  logic [7:0] tx_dat_o;
  logic       tx_vld_o;
  logic       tx_rdy_i;
  logic       ovf_o;

  modport slave (
    input  mbox_wr_i, mbox_di_i, tx_rdy_i,
    output mbox_full_o, mbox_afull_o, tx_dat_o, tx_vld_o, ovf_o
  );

  modport master (
    output mbox_wr_i, mbox_di_i, tx_rdy_i,
    input  mbox_full_o, mbox_afull_o, tx_dat_o, tx_vld_o, ovf_o
  );
endinterface

// File: rtl/mbox_framer.sv
// Buffers mailbox bytes and emits {SYNC, LEN, payload, CKS} frames over valid/ready.
// Define MBOX_FRAMER_CRC_EN for a CRC-8 (poly 0x07) CKS instead of the additive checksum.
module mbox_framer #(
  parameter int         AW        = 6,
  parameter int         MAX_PLD   = 16,
  parameter int         AFULL_LVL = 4,
  parameter int         TMO_W     = 8,
  parameter int         TIMEOUT   = 100,
  parameter logic [7:0] SYNC_BYTE = 8'h55
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  mbox_framer_if.slave bus
);

  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]    AFULL_C = CW'(AFULL_LVL);
  localparam logic [CW-1:0]    MAX_C   = CW'(MAX_PLD);
  localparam logic [7:0]       MAX_B   = 8'(MAX_PLD);
  localparam logic [TMO_W-1:0] TMO_C   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_PLD, S_CKS} state_t;

`ifdef MBOX_FRAMER_CRC_EN
  function automatic logic [7:0] cks_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction
  function automatic logic [7:0] cks_fin(input logic [7:0] c);
    return c;
  endfunction
`else
  function automatic logic [7:0] cks_upd(input logic [7:0] c, input logic [7:0] b);
    return c + b;
  endfunction
  function automatic logic [7:0] cks_fin(input logic [7:0] c);
    return ~c + 8'd1;
  endfunction
`endif

  logic [7:0]       mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       rem_q, rem_d, cks_q, cks_d, tx_dat_q, tx_dat_d;
  logic             tx_vld_q, tx_vld_d, ovf_q, ovf_d;
  logic             full, afull, wr_acc, hs, pop, trig;
  logic [7:0]       len_sel, cks_nxt;

  always_comb begin
    full    = (cnt_q == DEPTH_C);
    afull   = ((DEPTH_C - cnt_q) <= AFULL_C);
    wr_acc  = bus.mbox_wr_i & ~full;
    hs      = tx_vld_q & bus.tx_rdy_i;
    pop     = hs & (state_q == S_PLD);
    trig    = (state_q == S_IDLE) &
              ((cnt_q >= MAX_C) | ((cnt_q != '0) & (tmo_q == TMO_C)));
    len_sel = (cnt_q >= MAX_C) ? MAX_B : 8'(cnt_q);
    cks_nxt = cks_upd(cks_q, tx_dat_q);

    state_d  = state_q;
    rem_d    = rem_q;
    cks_d    = cks_q;
    tx_dat_d = tx_dat_q;
    tx_vld_d = tx_vld_q;
    ovf_d    = ovf_q | (bus.mbox_wr_i & full);
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    if (wr_acc && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !wr_acc) cnt_d = cnt_q - CW'(1);

    tmo_d = tmo_q;
    if (wr_acc || trig || state_q != S_IDLE) tmo_d = '0;
    else if (cnt_q != '0 && tmo_q != TMO_C) tmo_d = tmo_q + TMO_W'(1);

    // tx_dat is loaded one step ahead so the output stays registered
    case (state_q)
      S_IDLE: if (trig) begin
        state_d  = S_SYNC;
        tx_vld_d = 1'b1;
        tx_dat_d = SYNC_BYTE;
        rem_d    = len_sel;
      end
      S_SYNC: if (hs) begin
        state_d  = S_LEN;
        tx_dat_d = rem_q;
      end
      S_LEN: if (hs) begin
        state_d  = S_PLD;
        cks_d    = cks_upd(8'h00, rem_q);
        tx_dat_d = mem_q[rd_ptr_q];
      end
      S_PLD: if (hs) begin
        cks_d = cks_nxt;
        if (rem_q == 8'd1) begin
          state_d  = S_CKS;
          tx_dat_d = cks_fin(cks_nxt);
        end else begin
          rem_d    = rem_q - 8'd1;
          tx_dat_d = mem_q[rd_ptr_q + AW'(1)];
        end
      end
      S_CKS: if (hs) begin
        state_d  = S_IDLE;
        tx_vld_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmo_q    <= '0;
      rem_q    <= '0;
      cks_q    <= '0;
      tx_dat_q <= '0;
      tx_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tmo_q    <= tmo_d;
      rem_q    <= rem_d;
      cks_q    <= cks_d;
      tx_dat_q <= tx_dat_d;
      tx_vld_q <= tx_vld_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live
  always_ff @(posedge wb_clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.mbox_di_i;
  end

  assign bus.mbox_full_o  = full;
  assign bus.mbox_afull_o = afull;
  assign bus.tx_dat_o     = tx_dat_q;
  assign bus.tx_vld_o     = tx_vld_q;
  assign bus.ovf_o        = ovf_q;

endmodule
